uart_frame_receiver: RTL and testbench
======================================

# uart_frame_receiver

Serial-side counterpart of the camera frame transmitter: receives the 8N1 UART byte stream a frame sender emits on its Tx line and writes each byte into a frame buffer at consecutive addresses. A frame-indicator input marks the start of a frame. The block sits on a host or loopback FPGA between the UART pin and a dual-port RAM write port, and reports frame completion and framing errors.

## Interface
Parameters:
- CLKS_PER_BIT, 1085: system clocks per UART bit (125 MHz / 115200 baud); must be ≥ 4
- BYTES_PER_FRAME, 9216: bytes per frame; must be ≤ 2^ADDR_W
- ADDR_W, 15: write-address width

Ports:
- i_Clk  in  1  system clock, all logic on rising edge
- i_Rst_n  in  1  synchronous, active-low reset
- i_Rx  in  1  UART serial input, idle high, asynchronous to i_Clk
- i_Frame_Start  in  1  frame indicator, asynchronous level; a rising edge arms a new frame
- o_Wr_En  out  1  one-cycle write strobe to buffer
- o_Wr_Addr  out  ADDR_W  write address, valid with o_Wr_En
- o_Wr_Data  out  8  received byte, valid with o_Wr_En
- o_Frame_Done  out  1  one-cycle pulse after the last byte of a frame is written
- o_Frame_Error  out  1  sticky framing-error flag, cleared on arm or reset
- o_Armed  out  1  high while a frame is being accepted

## Operation
- Synchronizers: i_Rx and i_Frame_Start each pass through 2 flops. Reset values are i_Rx sync = 1 and frame sync = 0. All logic below uses the synchronized signals. A third flop on the frame path gives rising-edge detect.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE: bit counter is 0. Wait for rx = 0, then go to START and clear the clock counter.
  - START: count CLKS_PER_BIT/2 (integer division) cycles, then sample.
    - rx = 0: go to DATA.
    - rx = 1: false start, return to IDLE with no write.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After 8 samples, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample and return to IDLE.
    - rx = 1 and armed: byte is valid; write it.
    - rx = 0: framing error; set o_Frame_Error and discard the byte.
    - Valid byte while not armed: silently discarded.
- Write: on the cycle after a valid stop sample, o_Wr_En = 1, o_Wr_Data = shift register, o_Wr_Addr = current address. The address increments on that same edge.
- Frame end: when the written address equals BYTES_PER_FRAME-1:
  - o_Frame_Done pulses together with that o_Wr_En cycle;
  - the address wraps to 0;
  - o_Armed drops on the next cycle.
- Arm: on a frame-start rising edge, set address = 0, clear o_Frame_Error, set o_Armed = 1, and force the byte FSM to IDLE, aborting any byte in flight with no write.
- Simultaneous arm and write strobe in the same cycle: the write still completes at its old address. Arm takes effect on the same edge, so the next address is 0.
- Counters: clock counter is ceil(log2 CLKS_PER_BIT) bits wide; bit counter is 3 bits. There is no address overflow beyond BYTES_PER_FRAME-1.
- Reset:
  - every output is 0 (o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Frame_Done, o_Frame_Error, o_Armed);
  - FSM = IDLE and counters = 0.
  - Reset mid-byte abandons the byte with no write.

## Timing
- Let T0 be the first i_Clk edge at which the synchronized rx is 0 (2–3 cycles after the pin falls).
- Start sample: T0 + CLKS_PER_BIT/2.
- Data bit k (k = 0..7): sampled at T0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Stop sample: T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT, which is T0+10307 at default.
- o_Wr_En high exactly one cycle: the cycle after the stop sample.
- The FSM is in IDLE on the cycle after the stop sample. A start bit that begins within the second half of the stop bit is therefore caught, so back-to-back bytes with zero idle time are supported.
- Arm latency: o_Armed rises 3–4 cycles after the i_Frame_Start pin rises (2-flop sync plus edge detect plus register).
- Tolerance: sampling at mid-bit must accept a ±2% baud mismatch over the 10-bit character.

## Test plan
Test plan overrides: CLKS_PER_BIT=16, BYTES_PER_FRAME=4 unless stated.
- Reset then idle line: all outputs 0, no o_Wr_En for 1000 cycles.
- Arm, then send 0xA5, 0x3C, 0xFF, 0x00 back-to-back:
  - writes at addresses 0, 1, 2, 3 with those data;
  - o_Frame_Done high only with the address-3 write;
  - o_Armed = 0 afterwards.
- Send 0x55 with the stop bit held 0: no write, o_Frame_Error = 1. Re-arm: o_Frame_Error = 0, address = 0.
- Glitch: rx low for 4 cycles, then high: no write, FSM back in IDLE, and the next byte 0x81 is received correctly at address 0.
- Rising edge on i_Frame_Start mid-byte after 1 byte is written: the aborted byte is not written, and the next full byte is written at address 0.
- Default parameters: a byte sent at 1.02× and at 0.98× nominal bit period is received correctly. Unarmed byte produces no write.

Source files
------------

// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver that writes each valid byte of an armed frame into a buffer
// at consecutive addresses, flagging frame completion and stop-bit errors.
module uart_frame_receiver #(
  parameter int unsigned CLKS_PER_BIT    = 1085,
  parameter int unsigned BYTES_PER_FRAME = 9216,
  parameter int unsigned ADDR_W          = 15
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Rx,
  input  logic              i_Frame_Start,
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [7:0]        o_Wr_Data,
  output logic              o_Frame_Done,
  output logic              o_Frame_Error,
  output logic              o_Armed
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BYTES_PER_FRAME - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic rx_meta_q, rx_sync_q;
  logic fs_meta_q, fs_sync_q, fs_prev_q;
  logic arm_c;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_ok_c, stop_err_c;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              armed_q, armed_d;

  // Two-flop synchronizers; the extra frame flop provides rising-edge detect
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      fs_meta_q <= 1'b0;
      fs_sync_q <= 1'b0;
      fs_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= i_Rx;
      rx_sync_q <= rx_meta_q;
      fs_meta_q <= i_Frame_Start;
      fs_sync_q <= fs_meta_q;
      fs_prev_q <= fs_sync_q;
    end
  end

  assign arm_c = fs_sync_q & ~fs_prev_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
    end
  end

  // Byte FSM: mid-bit sampling driven by a single clock counter
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_ok_c  = 1'b0;
    stop_err_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!rx_sync_q) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d  = '0;
          state_d    = S_IDLE;
          byte_ok_c  = rx_sync_q;
          stop_err_c = ~rx_sync_q;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Arming abandons whatever byte is in flight
    if (arm_c) begin
      state_d    = S_IDLE;
      clk_cnt_d  = '0;
      bit_cnt_d  = '0;
      byte_ok_c  = 1'b0;
      stop_err_c = 1'b0;
    end
  end

  // Write strobe, addressing and frame status
  always_comb begin
    wr_en_d   = byte_ok_c & armed_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    addr_d    = addr_q;
    err_d     = err_q | stop_err_c;
    armed_d   = armed_q;
    if (byte_ok_c && armed_q) begin
      wr_addr_d = addr_q;
      wr_data_d = shift_q;
      done_d    = (addr_q == ADDR_LAST);
      addr_d    = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
    end
    if (done_q) armed_d = 1'b0;
    // An arm coinciding with a write strobe lets the write finish at its old address
    if (arm_c) begin
      addr_d  = '0;
      err_d   = 1'b0;
      armed_d = 1'b1;
    end
  end

  assign o_Wr_En       = wr_en_q;
  assign o_Wr_Addr     = wr_addr_q;
  assign o_Wr_Data     = wr_data_q;
  assign o_Frame_Done  = done_q;
  assign o_Frame_Error = err_q;
  assign o_Armed       = armed_q;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Bench for uart_frame_receiver: a small-parameter instance for protocol scenarios and
// a default-parameter instance for baud tolerance, both checked against a frame model.
module tb_uart_frame_receiver;

  localparam int unsigned S_CPB = 16;
  localparam int unsigned S_BPF = 4;
  localparam int unsigned D_CPB = 1085;
  localparam int unsigned D_BPF = 9216;
  localparam int unsigned AW    = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rx_s, fs_s, rx_d, fs_d;
  logic wr_s, done_s, err_s, armed_s;
  logic wr_d, done_d, err_d, armed_d;
  logic [AW-1:0] addr_s, addr_d;
  logic [7:0] data_s, data_d;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          done;
  } wr_t;

  wr_t got_s[$];
  wr_t got_d[$];
  wr_t exp_s[$];

  int checks = 0;
  int errors = 0;
  int stray_done = 0;

  int m_addr;
  bit m_armed;
  bit m_err;

  uart_frame_receiver #(.CLKS_PER_BIT(S_CPB), .BYTES_PER_FRAME(S_BPF), .ADDR_W(AW)) dut_s (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Rx(rx_s), .i_Frame_Start(fs_s),
    .o_Wr_En(wr_s), .o_Wr_Addr(addr_s), .o_Wr_Data(data_s),
    .o_Frame_Done(done_s), .o_Frame_Error(err_s), .o_Armed(armed_s)
  );

  uart_frame_receiver #(.CLKS_PER_BIT(D_CPB), .BYTES_PER_FRAME(D_BPF), .ADDR_W(AW)) dut_d (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Rx(rx_d), .i_Frame_Start(fs_d),
    .o_Wr_En(wr_d), .o_Wr_Addr(addr_d), .o_Wr_Data(data_d),
    .o_Frame_Done(done_d), .o_Frame_Error(err_d), .o_Armed(armed_d)
  );

  // Record every write strobe; a done pulse without a write is logged separately
  always @(negedge clk) begin
    wr_t w;
    if (wr_s === 1'b1) begin
      w.addr = addr_s; w.data = data_s; w.done = done_s;
      got_s.push_back(w);
    end
    if (wr_d === 1'b1) begin
      w.addr = addr_d; w.data = data_d; w.done = done_d;
      got_d.push_back(w);
    end
    if ((done_s === 1'b1 && wr_s !== 1'b1) || (done_d === 1'b1 && wr_d !== 1'b1))
      stray_done++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_rx(input bit to_d, input logic v);
    if (to_d) rx_d = v;
    else rx_s = v;
  endtask

  task automatic send_byte(input bit to_d, input logic [7:0] b, input logic stop, input int period);
    drive_rx(to_d, 1'b0);
    wait_cyc(period);
    for (int i = 0; i < 8; i++) begin
      drive_rx(to_d, b[i]);
      wait_cyc(period);
    end
    drive_rx(to_d, stop);
    wait_cyc(period);
    drive_rx(to_d, 1'b1);
  endtask

  task automatic pulse_arm(input bit to_d);
    if (to_d) fs_d = 1'b1;
    else fs_s = 1'b1;
    wait_cyc(8);
    if (to_d) fs_d = 1'b0;
    else fs_s = 1'b0;
    wait_cyc(4);
  endtask

  task automatic model_arm();
    m_addr  = 0;
    m_armed = 1'b1;
    m_err   = 1'b0;
  endtask

  // Frame-level model: valid armed bytes land at consecutive addresses, last one ends the frame
  task automatic model_byte(input logic [7:0] b, input logic stop);
    wr_t w;
    if (!stop) begin
      m_err = 1'b1;
    end else if (m_armed) begin
      w.addr = AW'(m_addr);
      w.data = b;
      w.done = (m_addr == int'(S_BPF) - 1);
      exp_s.push_back(w);
      if (w.done) begin
        m_addr  = 0;
        m_armed = 1'b0;
      end else begin
        m_addr++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_s = 1'b1; rx_d = 1'b1; fs_s = 1'b0; fs_d = 1'b0;
    m_addr = 0; m_armed = 1'b0; m_err = 1'b0;
    wait_cyc(5);
    checks++;
    if ({wr_s, addr_s, data_s, done_s, err_s, armed_s} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_s: got %0h expected 0", {wr_s, addr_s, data_s, done_s, err_s, armed_s});
    end
    checks++;
    if ({wr_d, addr_d, data_d, done_d, err_d, armed_d} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_d: got %0h expected 0", {wr_d, addr_d, data_d, done_d, err_d, armed_d});
    end
    rst_n = 1'b1;
    wait_cyc(1000);
    checks++;
    if (got_s.size() + got_d.size() != 0) begin
      errors++;
      $display("FAIL idle_no_write: got %0d writes expected 0", got_s.size() + got_d.size());
    end
    checks++;
    if ({wr_s, addr_s, data_s, done_s, err_s, armed_s} !== '0) begin
      errors++;
      $display("FAIL idle_outputs_s: got %0h expected 0", {wr_s, addr_s, data_s, done_s, err_s, armed_s});
    end
  endtask

  task automatic test_unarmed();
    logic [7:0] b;
    b = 8'($urandom);
    send_byte(1'b0, b, 1'b1, S_CPB);
    model_byte(b, 1'b1);
    wait_cyc(20);
    checks++;
    if (got_s.size() != exp_s.size()) begin
      errors++;
      $display("FAIL unarmed_no_write: got %0d writes expected %0d", got_s.size(), exp_s.size());
    end
    checks++;
    if (err_s !== 1'b0) begin
      errors++;
      $display("FAIL unarmed_error: got %b expected 0", err_s);
    end
  endtask

  task automatic test_frame();
    logic [7:0] seq [4];
    int lat;
    seq = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    fs_s = 1'b1;
    lat = 0;
    while (armed_s !== 1'b1 && lat < 10) begin
      wait_cyc(1);
      lat++;
    end
    checks++;
    if (lat < 3 || lat > 4) begin
      errors++;
      $display("FAIL arm_latency: got %0d cycles expected 3..4", lat);
    end
    wait_cyc(5);
    fs_s = 1'b0;
    wait_cyc(4);
    model_arm();
    for (int i = 0; i < 4; i++) begin
      send_byte(1'b0, seq[i], 1'b1, S_CPB);
      model_byte(seq[i], 1'b1);
    end
    wait_cyc(20);
    checks++;
    if (got_s.size() != exp_s.size()) begin
      errors++;
      $display("FAIL frame_count: got %0d writes expected %0d", got_s.size(), exp_s.size());
    end
    for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
      checks++;
      if (got_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL frame_write%0d: got addr %0d data %h done %b expected addr %0d data %h done %b",
                 i, got_s[i].addr, got_s[i].data, got_s[i].done, exp_s[i].addr, exp_s[i].data, exp_s[i].done);
      end
    end
    checks++;
    if (armed_s !== m_armed) begin
      errors++;
      $display("FAIL frame_disarm: got armed %b expected %b", armed_s, m_armed);
    end
    checks++;
    if (stray_done != 0) begin
      errors++;
      $display("FAIL frame_done_alone: got %0d stray pulses expected 0", stray_done);
    end
    got_s.delete();
    exp_s.delete();
  endtask

  task automatic test_frame_error();
    pulse_arm(1'b0);
    model_arm();
    send_byte(1'b0, 8'h55, 1'b0, S_CPB);
    model_byte(8'h55, 1'b0);
    wait_cyc(2 * S_CPB);
    checks++;
    if (got_s.size() != 0) begin
      errors++;
      $display("FAIL ferr_no_write: got %0d writes expected 0", got_s.size());
    end
    checks++;
    if (err_s !== m_err) begin
      errors++;
      $display("FAIL ferr_flag: got %b expected %b", err_s, m_err);
    end
    pulse_arm(1'b0);
    model_arm();
    checks++;
    if (err_s !== m_err || armed_s !== m_armed) begin
      errors++;
      $display("FAIL rearm_clear: got err %b armed %b expected err %b armed %b", err_s, armed_s, m_err, m_armed);
    end
  endtask

  task automatic test_glitch();
    rx_s = 1'b0;
    wait_cyc(4);
    rx_s = 1'b1;
    wait_cyc(40);
    checks++;
    if (got_s.size() != 0) begin
      errors++;
      $display("FAIL glitch_no_write: got %0d writes expected 0", got_s.size());
    end
    send_byte(1'b0, 8'h81, 1'b1, S_CPB);
    model_byte(8'h81, 1'b1);
    wait_cyc(20);
    checks++;
    if (got_s.size() != 1 || got_s[0] !== exp_s[0]) begin
      errors++;
      $display("FAIL glitch_next_byte: got %0d writes first %h expected 1 write %h",
               got_s.size(), (got_s.size() > 0) ? got_s[0] : wr_t'(0), exp_s[0]);
    end
    got_s.delete();
    exp_s.delete();
  endtask

  task automatic test_abort();
    logic [7:0] b;
    pulse_arm(1'b0);
    model_arm();
    b = 8'($urandom);
    send_byte(1'b0, b, 1'b1, S_CPB);
    model_byte(b, 1'b1);
    wait_cyc(4);
    // Re-arm lands inside data bit 5 of 0xF0, where the line stays high to the stop bit
    fork
      send_byte(1'b0, 8'hF0, 1'b1, S_CPB);
      begin
        wait_cyc(6 * S_CPB + S_CPB / 2);
        fs_s = 1'b1;
        wait_cyc(6);
        fs_s = 1'b0;
      end
    join
    model_arm();
    wait_cyc(10);
    b = 8'($urandom);
    send_byte(1'b0, b, 1'b1, S_CPB);
    model_byte(b, 1'b1);
    wait_cyc(20);
    checks++;
    if (got_s.size() != exp_s.size()) begin
      errors++;
      $display("FAIL abort_count: got %0d writes expected %0d", got_s.size(), exp_s.size());
    end
    for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
      checks++;
      if (got_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL abort_write%0d: got %h expected %h", i, got_s[i], exp_s[i]);
      end
    end
    got_s.delete();
    exp_s.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic ok;
    for (int r = 0; r < 3; r++) begin
      pulse_arm(1'b0);
      model_arm();
      for (int n = 0; n < 7; n++) begin
        b  = 8'($urandom);
        ok = ($urandom_range(0, 3) != 0);
        send_byte(1'b0, b, ok, S_CPB);
        model_byte(b, ok);
        if (!ok) wait_cyc(2 * S_CPB);
        else wait_cyc($urandom_range(0, 5));
      end
      wait_cyc(20);
      checks++;
      if (got_s.size() != exp_s.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d writes expected %0d", r, got_s.size(), exp_s.size());
      end
      for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
        checks++;
        if (got_s[i] !== exp_s[i]) begin
          errors++;
          $display("FAIL rand%0d_write%0d: got %h expected %h", r, i, got_s[i], exp_s[i]);
        end
      end
      checks++;
      if (err_s !== m_err || armed_s !== m_armed) begin
        errors++;
        $display("FAIL rand%0d_status: got err %b armed %b expected err %b armed %b",
                 r, err_s, armed_s, m_err, m_armed);
      end
      got_s.delete();
      exp_s.delete();
    end
  endtask

  task automatic test_default_baud();
    logic [7:0] b0, b1;
    wr_t e;
    b0 = 8'($urandom);
    send_byte(1'b1, b0, 1'b1, D_CPB);
    wait_cyc(20);
    checks++;
    if (got_d.size() != 0) begin
      errors++;
      $display("FAIL default_unarmed: got %0d writes expected 0", got_d.size());
    end
    pulse_arm(1'b1);
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    send_byte(1'b1, b0, 1'b1, 1107);
    send_byte(1'b1, b1, 1'b1, 1063);
    wait_cyc(20);
    checks++;
    if (got_d.size() != 2) begin
      errors++;
      $display("FAIL baud_count: got %0d writes expected 2", got_d.size());
    end
    e.addr = AW'(0); e.data = b0; e.done = 1'b0;
    checks++;
    if (got_d.size() < 1 || got_d[0] !== e) begin
      errors++;
      $display("FAIL baud_slow: got %h expected %h", (got_d.size() > 0) ? got_d[0] : wr_t'(0), e);
    end
    e.addr = AW'(1); e.data = b1; e.done = 1'b0;
    checks++;
    if (got_d.size() < 2 || got_d[1] !== e) begin
      errors++;
      $display("FAIL baud_fast: got %h expected %h", (got_d.size() > 1) ? got_d[1] : wr_t'(0), e);
    end
    checks++;
    if (armed_d !== 1'b1 || err_d !== 1'b0) begin
      errors++;
      $display("FAIL baud_status: got armed %b err %b expected armed 1 err 0", armed_d, err_d);
    end
  endtask

  initial begin
    test_reset();
    test_unarmed();
    test_frame();
    test_frame_error();
    test_glitch();
    test_abort();
    test_random();
    test_default_baud();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
